// File: rtl/ijtag_host_pkg.sv
// Shared types and constants for the IJTAG scan host.
package ijtag_host_pkg;

    localparam int MAX_LEN      = 64;
    localparam int LEN_W        = $clog2(MAX_LEN + 1);
    localparam int RESET_CYCLES = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        NRESET  = 3'd1,
        CAPTURE = 3'd2,
        SHIFT   = 3'd3,
        UPDATE  = 3'd4,
        GAP     = 3'd5,
        RESP    = 3'd6
    } state_t;

    typedef struct packed {
        logic [LEN_W-1:0]   len;
        logic [MAX_LEN-1:0] data;
        logic               skip_capture;
        logic               skip_update;
        logic               net_reset;
    } req_t;

    // State that follows the shift phase (or an empty shift phase).
    function automatic state_t after_shift(input logic skip_update);
        if (!skip_update) begin
            return UPDATE;
        end else begin
            return GAP;
        end
    endfunction

    // State that follows CAPTURE (or acceptance when capture is skipped).
    function automatic state_t after_capture(input logic [LEN_W-1:0] len,
                                             input logic             skip_update);
        if (len != {LEN_W{1'b0}}) begin
            return SHIFT;
        end else begin
            return after_shift(skip_update);
        end
    endfunction

endpackage

// File: rtl/ijtag_host_shifter.sv
// Data path of the scan host: outgoing data, captured response, bit counter,
// si drive and so sampling. The FSM in the top level sequences it.
module ijtag_host_shifter #(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 7
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [MAX_LEN-1:0] i_data,
    input  logic [LEN_W-1:0]   i_len,
    input  logic               i_shift,
    input  logic               i_si_next,
    input  logic               i_so,
    output logic               o_si,
    output logic               o_last,
    output logic [MAX_LEN-1:0] o_resp_data
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [MAX_LEN-1:0] r_data;
    logic [MAX_LEN-1:0] r_resp;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_si;
    logic               w_last;

    // Last shift cycle once the counter reaches len-1; the counter never wraps.
    assign w_last      = (r_cnt == (i_len - LEN_W'(1)));
    assign o_last      = w_last;
    assign o_si        = r_si;
    assign o_resp_data = r_resp;

    // Load on acceptance, then shift out LSB first and record so per cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data <= '0;
            r_resp <= '0;
            r_cnt  <= '0;
            r_si   <= 1'b0;
        end else begin
            if (i_load) begin
                r_data <= i_data;
                r_resp <= '0;
                r_cnt  <= '0;
            end else if (i_shift) begin
                r_data                  <= r_data >> 1;
                r_resp[r_cnt[IDX_W-1:0]] <= i_so;
                if (!w_last) begin
                    r_cnt <= r_cnt + LEN_W'(1);
                end
            end
            // si is registered one cycle ahead so it is valid for the whole
            // shift cycle; it is forced low outside SHIFT.
            if (!i_si_next) begin
                r_si <= 1'b0;
            end else if (i_shift) begin
                r_si <= r_data[1];
            end else if (i_load) begin
                r_si <= i_data[0];
            end else begin
                r_si <= r_data[0];
            end
        end
    end

endmodule

// File: rtl/ijtag_scan_host.sv
// IJTAG network initiator: turns one parallel scan request into a
// CAPTURE/SHIFT/UPDATE sequence (or a network reset pulse) and returns
// the bits observed on ijtag_so.
module ijtag_scan_host
    import ijtag_host_pkg::*;
#(
    parameter int MAX_LEN      = ijtag_host_pkg::MAX_LEN,
    parameter int LEN_W        = $clog2(MAX_LEN + 1),
    parameter int RESET_CYCLES = ijtag_host_pkg::RESET_CYCLES
) (
    input  logic               ijtag_tck,
    input  logic               ijtag_reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [LEN_W-1:0]   req_len,
    input  logic [MAX_LEN-1:0] req_data,
    input  logic               req_skip_capture,
    input  logic               req_skip_update,
    input  logic               req_net_reset,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [MAX_LEN-1:0] resp_data,
    output logic               resp_err,
    output logic               ijtag_sel,
    output logic               ijtag_ce,
    output logic               ijtag_se,
    output logic               ijtag_ue,
    output logic               ijtag_si,
    input  logic               ijtag_so,
    output logic               ijtag_to_reset
);

    localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    state_t           r_state;
    state_t           w_next;
    req_t             w_req;
    logic             w_accept;
    logic             w_len_err;
    logic             w_last;
    logic             w_shift;
    logic             w_si_next;
    logic [LEN_W-1:0] r_len;
    logic             r_skip_update;
    logic             r_len_err;
    logic [RC_W-1:0]  r_rst_cnt;
    logic             r_req_ready;
    logic             r_resp_valid;
    logic             r_resp_err;
    logic             r_sel;
    logic             r_ce;
    logic             r_se;
    logic             r_ue;
    logic             r_to_reset;

    assign w_req.len          = req_len;
    assign w_req.data         = req_data;
    assign w_req.skip_capture = req_skip_capture;
    assign w_req.skip_update  = req_skip_update;
    assign w_req.net_reset    = req_net_reset;

    assign w_accept  = req_valid && r_req_ready;
    // Over-length requests are rejected, but a network reset ignores len.
    assign w_len_err = !w_req.net_reset && (w_req.len > LEN_W'(MAX_LEN));
    assign w_shift   = (r_state == SHIFT);
    assign w_si_next = (w_next == SHIFT);

    // Next-state decode of the scan sequence.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_req.net_reset) begin
                        w_next = NRESET;
                    end else if (w_len_err) begin
                        w_next = RESP;
                    end else if (!w_req.skip_capture) begin
                        w_next = CAPTURE;
                    end else begin
                        w_next = after_capture(w_req.len, w_req.skip_update);
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            NRESET: begin
                if (r_rst_cnt == RC_W'(RESET_CYCLES - 1)) begin
                    w_next = GAP;
                end else begin
                    w_next = NRESET;
                end
            end
            CAPTURE: w_next = after_capture(r_len, r_skip_update);
            SHIFT: begin
                if (w_last) begin
                    w_next = after_shift(r_skip_update);
                end else begin
                    w_next = SHIFT;
                end
            end
            UPDATE:  w_next = GAP;
            GAP:     w_next = RESP;
            RESP: begin
                if (resp_ready) begin
                    w_next = IDLE;
                end else begin
                    w_next = RESP;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // FSM state, request fields and all network/handshake outputs, each
    // registered from the next state so nothing is combinational to a pin.
    always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset) begin
            r_state       <= IDLE;
            r_len         <= '0;
            r_skip_update <= 1'b0;
            r_len_err     <= 1'b0;
            r_rst_cnt     <= '0;
            r_req_ready   <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_resp_err    <= 1'b0;
            r_sel         <= 1'b0;
            r_ce          <= 1'b0;
            r_se          <= 1'b0;
            r_ue          <= 1'b0;
            r_to_reset    <= 1'b1;
        end else begin
            r_state      <= w_next;
            r_sel        <= (w_next == CAPTURE) || (w_next == SHIFT) || (w_next == UPDATE);
            r_ce         <= (w_next == CAPTURE);
            r_se         <= (w_next == SHIFT);
            r_ue         <= (w_next == UPDATE);
            r_to_reset   <= (w_next != NRESET);
            r_req_ready  <= (w_next == IDLE);
            r_resp_valid <= (w_next == RESP);
            r_resp_err   <= (w_next == RESP) && (w_accept ? w_len_err : r_len_err);
            if (w_accept) begin
                r_len         <= w_req.len;
                r_skip_update <= w_req.skip_update;
                r_len_err     <= w_len_err;
            end
            if (r_state == NRESET) begin
                r_rst_cnt <= r_rst_cnt + RC_W'(1);
            end else begin
                r_rst_cnt <= '0;
            end
        end
    end

    ijtag_host_shifter #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_shifter (
        .i_clk       (ijtag_tck),
        .i_rst       (ijtag_reset),
        .i_load      (w_accept),
        .i_data      (w_req.data),
        .i_len       (r_len),
        .i_shift     (w_shift),
        .i_si_next   (w_si_next),
        .i_so        (ijtag_so),
        .o_si        (ijtag_si),
        .o_last      (w_last),
        .o_resp_data (resp_data)
    );

    assign req_ready      = r_req_ready;
    assign resp_valid     = r_resp_valid;
    assign resp_err       = r_resp_err;
    assign ijtag_sel      = r_sel;
    assign ijtag_ce       = r_ce;
    assign ijtag_se       = r_se;
    assign ijtag_ue       = r_ue;
    assign ijtag_to_reset = r_to_reset;

endmodule

// File: tb/tb_ijtag_scan_host.sv
// Directed bench for ijtag_scan_host with an 8-bit TDR and a SIB latch model.
module tb_ijtag_scan_host;

    logic        tck = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  req_len = 7'd0;
    logic [63:0] req_data = 64'd0;
    logic        req_sc = 1'b0;
    logic        req_su = 1'b0;
    logic        req_nr = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_data;
    logic        resp_err;
    logic        sel, ce, se, ue, si, to_reset;
    logic        so;

    int checks = 0;
    int errors = 0;

    // monitor counters, sampled on the falling edge
    int ce_n = 0, se_n = 0, ue_n = 0, sel_n = 0, rlo_n = 0, sel_rst_n = 0, rv_n = 0, viol = 0;
    logic [63:0] si_hist = 64'd0;

    // network model: 8-bit TDR (capture value 0x3C) and one SIB latch
    logic [7:0] tdr_sh;
    logic [7:0] tdr_upd;
    logic       sib_latch;

    always #5 tck = ~tck;

    ijtag_scan_host dut (
        .ijtag_tck        (tck),
        .ijtag_reset      (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_len          (req_len),
        .req_data         (req_data),
        .req_skip_capture (req_sc),
        .req_skip_update  (req_su),
        .req_net_reset    (req_nr),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_data        (resp_data),
        .resp_err         (resp_err),
        .ijtag_sel        (sel),
        .ijtag_ce         (ce),
        .ijtag_se         (se),
        .ijtag_ue         (ue),
        .ijtag_si         (si),
        .ijtag_so         (so),
        .ijtag_to_reset   (to_reset)
    );

    always @(posedge tck) begin
        if (sel && ce) tdr_sh <= 8'h3C;
        else if (sel && se) tdr_sh <= {si, tdr_sh[7:1]};
        if (sel && ue) tdr_upd <= tdr_sh;
    end

    always @(negedge tck) so <= tdr_sh[0];

    always @(posedge tck or negedge to_reset) begin
        if (!to_reset) sib_latch <= 1'b0;
        else if (sel && ue) sib_latch <= tdr_sh[7];
    end

    always @(negedge tck) begin
        if (ce) ce_n++;
        if (ue) ue_n++;
        if (sel) sel_n++;
        if (resp_valid) rv_n++;
        if (se) begin
            se_n++;
            si_hist = {si_hist[62:0], si};
        end
        if (!to_reset) begin
            rlo_n++;
            if (sel) sel_rst_n++;
        end
        if ((int'(ce) + int'(se) + int'(ue)) > 1 || ((ce || se || ue) && !sel)) viol++;
    end

    // Issue one request, count edges from the acceptance edge until resp_valid.
    task automatic run_req(input logic [6:0] len, input logic [63:0] data,
                           input logic sc, input logic su, input logic nr,
                           output int lat);
        int n;
        n = 0;
        @(negedge tck);
        while (!req_ready && n < 100) begin
            @(negedge tck);
            n++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL req_ready_wait got 0 expected 1");
        end
        req_len = len; req_data = data; req_sc = sc; req_su = su; req_nr = nr;
        req_valid = 1'b1;
        @(posedge tck);
        lat = 1;
        @(negedge tck);
        req_valid = 1'b0;
        req_len = ~len; req_data = ~data; req_sc = ~sc; req_su = ~su; req_nr = 1'b0;
        while (!resp_valid && lat < 200) begin
            @(posedge tck);
            lat++;
            @(negedge tck);
        end
        checks++;
        if (!resp_valid) begin
            errors++;
            $display("FAIL resp_timeout got resp_valid=0 expected 1 after %0d cycles", lat);
        end
    endtask

    task automatic consume();
        @(negedge tck);
        resp_ready = 1'b1;
        @(posedge tck);
        @(negedge tck);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge tck);
        checks++;
        if ({sel, ce, se, ue, si, to_reset, resp_valid, resp_err} !== 8'b0000_0100 || resp_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b/%h expected 00000100/0",
                     {sel, ce, se, ue, si, to_reset, resp_valid, resp_err}, resp_data);
        end
        rst = 1'b0;
        @(posedge tck); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b expected 1", req_ready);
        end
        // pulse reset again while idle
        @(negedge tck);
        rst = 1'b1;
        #1;
        checks++;
        if ({sel, ce, se, ue, si, to_reset, resp_valid} !== 7'b0000_010) begin
            errors++;
            $display("FAIL idle_reset_outputs got %b expected 0000010",
                     {sel, ce, se, ue, si, to_reset, resp_valid});
        end
        @(negedge tck);
        rst = 1'b0;
        @(posedge tck); #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_reset_ready got ready=%b valid=%b expected 1/0", req_ready, resp_valid);
        end
    endtask

    task automatic test_len8();
        int lat, c0, s0, u0;
        c0 = ce_n; s0 = se_n; u0 = ue_n;
        run_req(7'd8, 64'hA5, 1'b0, 1'b0, 1'b0, lat);
        checks++;
        if (lat != 12) begin errors++; $display("FAIL len8_latency got %0d expected 12", lat); end
        checks++;
        if (resp_data !== 64'h3C || resp_err !== 1'b0) begin
            errors++; $display("FAIL len8_resp got %h err=%b expected 3c err=0", resp_data, resp_err);
        end
        checks++;
        if (ce_n - c0 != 1 || se_n - s0 != 8 || ue_n - u0 != 1) begin
            errors++; $display("FAIL len8_phases got ce=%0d se=%0d ue=%0d expected 1/8/1", ce_n - c0, se_n - s0, ue_n - u0);
        end
        checks++;
        if (si_hist[7:0] !== 8'hA5) begin errors++; $display("FAIL len8_si got %b expected 10100101", si_hist[7:0]); end
        checks++;
        if (tdr_upd !== 8'hA5) begin errors++; $display("FAIL len8_tdr_update got %h expected a5", tdr_upd); end
        consume();
    endtask

    task automatic test_net_reset();
        int lat, r0, sr0, s0;
        checks++;
        if (sib_latch !== 1'b1) begin errors++; $display("FAIL sib_before got %b expected 1", sib_latch); end
        r0 = rlo_n; sr0 = sel_rst_n; s0 = sel_n;
        run_req(7'd8, 64'hFF, 1'b0, 1'b0, 1'b1, lat);
        checks++;
        if (rlo_n - r0 != 4 || sel_rst_n - sr0 != 0 || sel_n - s0 != 0) begin
            errors++; $display("FAIL nreset_pulse got low=%0d sel=%0d expected 4/0", rlo_n - r0, sel_n - s0);
        end
        checks++;
        if (lat != 6 || resp_err !== 1'b0 || resp_data !== 64'd0) begin
            errors++; $display("FAIL nreset_resp got lat=%0d err=%b data=%h expected 6/0/0", lat, resp_err, resp_data);
        end
        checks++;
        if (sib_latch !== 1'b0) begin errors++; $display("FAIL sib_after got %b expected 0", sib_latch); end
        consume();
    endtask

    task automatic test_len0_and_overlen();
        int lat, c0, s0, u0, sl0;
        c0 = ce_n; s0 = se_n; u0 = ue_n;
        run_req(7'd0, 64'hFF, 1'b0, 1'b0, 1'b0, lat);
        checks++;
        if (ce_n - c0 != 1 || se_n - s0 != 0 || ue_n - u0 != 1 || lat != 4) begin
            errors++; $display("FAIL len0_phases got ce=%0d se=%0d ue=%0d lat=%0d expected 1/0/1/4", ce_n - c0, se_n - s0, ue_n - u0, lat);
        end
        checks++;
        if (resp_data !== 64'd0 || resp_err !== 1'b0) begin
            errors++; $display("FAIL len0_resp got %h err=%b expected 0 err=0", resp_data, resp_err);
        end
        consume();
        sl0 = sel_n;
        run_req(7'd65, 64'hFFFF, 1'b0, 1'b0, 1'b0, lat);
        checks++;
        if (sel_n - sl0 != 0 || resp_err !== 1'b1 || resp_data !== 64'd0) begin
            errors++; $display("FAIL overlen got sel=%0d err=%b data=%h expected 0/1/0", sel_n - sl0, resp_err, resp_data);
        end
        consume();
    endtask

    task automatic test_skip();
        int lat, c0, s0, u0;
        c0 = ce_n; s0 = se_n; u0 = ue_n;
        run_req(7'd4, 64'hF, 1'b1, 1'b1, 1'b0, lat);
        checks++;
        if (ce_n - c0 != 0 || se_n - s0 != 4 || ue_n - u0 != 0 || lat != 6) begin
            errors++; $display("FAIL skip_phases got ce=%0d se=%0d ue=%0d lat=%0d expected 0/4/0/6", ce_n - c0, se_n - s0, ue_n - u0, lat);
        end
        checks++;
        if (si_hist[3:0] !== 4'hF || resp_data !== 64'hC) begin
            errors++; $display("FAIL skip_data got si=%b resp=%h expected 1111/c", si_hist[3:0], resp_data);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic ok;
        run_req(7'd8, 64'h5A, 1'b0, 1'b0, 1'b0, lat);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge tck);
            @(negedge tck);
            if (resp_valid !== 1'b1 || resp_data !== 64'h3C || req_ready !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL backpressure got valid=%b data=%h ready=%b expected 1/3c/0", resp_valid, resp_data, req_ready);
        end
        consume();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL after_consume got valid=%b ready=%b expected 0/1", resp_valid, req_ready);
        end
    endtask

    task automatic test_abort();
        int u0, v0, k, n;
        u0 = ue_n; v0 = rv_n; k = 0; n = 0;
        @(negedge tck);
        req_len = 7'd8; req_data = 64'hFF; req_sc = 1'b0; req_su = 1'b0; req_nr = 1'b0;
        req_valid = 1'b1;
        @(posedge tck);
        @(negedge tck);
        req_valid = 1'b0;
        while (k < 4 && n < 50) begin
            #1;
            if (se) k++;
            if (k < 4) @(negedge tck);
            n++;
        end
        checks++;
        if (k != 4) begin errors++; $display("FAIL abort_reach_shift got %0d expected 4", k); end
        rst = 1'b1;
        #1;
        checks++;
        if (se !== 1'b0 || sel !== 1'b0 || to_reset !== 1'b1) begin
            errors++; $display("FAIL abort_async got se=%b sel=%b to_reset=%b expected 0/0/1", se, sel, to_reset);
        end
        repeat (2) @(negedge tck);
        rst = 1'b0;
        repeat (20) @(negedge tck);
        checks++;
        if (ue_n - u0 != 0 || rv_n - v0 != 0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL abort_quiet got ue=%0d rv=%0d ready=%b expected 0/0/1", ue_n - u0, rv_n - v0, req_ready);
        end
    endtask

    initial begin
        test_reset();
        test_len8();
        test_net_reset();
        test_len0_and_overlen();
        test_skip();
        test_back_to_back();
        test_abort();
        checks++;
        if (viol != 0) begin errors++; $display("FAIL enable_exclusive got %0d violations expected 0", viol); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
